mem_ctrl_rv: RTL and testbench
==============================

// Module: mem_ctrl_rv
// PURPOSE
//  Parametrised single-port RAM controller with valid/ready request and response channels.
//  Supports byte-enabled writes, configurable read latency and an out-of-range error response.
//  Every accepted request, read or write, returns exactly one in-order response.
//  A credit-checked response FIFO provides back-pressure.
//  Sits between a bus master/FSM and on-chip storage; supersedes the fixed 8x256 wrapper.
// PARAMETERS
//  DATA_W      32   data width in bits; multiple of 8
//  DEPTH       256  number of words; need not be a power of two
//  READ_LAT    1    array-to-response latency in edges, 1 or 2
//  RESP_DEPTH  4    response FIFO entries; must be >= READ_LAT+1
//  ADDR_W = $clog2(DEPTH) and BE_W = DATA_W/8 are derived localparams, not overridable
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  req_valid   in   1        request present
//  req_ready   out  1        controller can accept a request this cycle
//  req_we      in   1        1 = write, 0 = read
//  req_addr    in   ADDR_W   word address
//  req_wdata   in   DATA_W   write data
//  req_be      in   BE_W     byte enables (writes only); bit i covers bits [8i+7:8i]
//  resp_valid  out  1        response at FIFO head
//  resp_ready  in   1        consumer takes response
//  resp_rdata  out  DATA_W   read data; 0 for writes and errors
//  resp_is_wr  out  1        response belongs to a write
//  resp_err    out  1        request addressed a word >= DEPTH
// BEHAVIOUR
//  - Accept: a request is accepted when req_valid && req_ready at the rising edge (edge E1).
//  - Credits: outstanding = in_flight (pipeline stages) + fifo_count.
//    req_ready = !rst && (outstanding < RESP_DEPTH); it is a purely registered-state function.
//    req_ready does not depend on req_valid or on resp_ready in the same cycle.
//  - Writes: at E1, array bytes with req_be=1 are updated; bytes with req_be=0 keep their value.
//    Writes with req_be=0 still respond (resp_is_wr=1, resp_err=0).
//  - Reads: array sampled at E1. resp_valid first rises in the cycle after edge E(READ_LAT),
//    provided the FIFO was empty. Otherwise the response queues behind older responses, in order.
//  - Read-after-write: a read accepted at E2 returns data written at E1 (no stale data).
//    The array is single-port, so a same-edge read and write cannot occur.
//  - Errors: addr >= DEPTH -> no array access; response has resp_err=1, rdata=0.
//    Error responses have the same latency and ordering as normal responses.
//  - Pop: a response is removed when resp_valid && resp_ready.
//    resp_* are stable while resp_valid=1 && resp_ready=0.
//  - Simultaneous accept and pop: outstanding is unchanged; both take effect.
//  - FIFO full: if outstanding==RESP_DEPTH, req_ready=0. A pop in that cycle re-raises req_ready
//    in the next cycle, not combinationally.
//  - FIFO pointers wrap modulo RESP_DEPTH; the count is separate, ADDR-independent, $clog2(RESP_DEPTH+1) bits.
//  - Reset: at any edge with rst=1, the pipeline valids, FIFO pointers/count and outputs clear.
//    After reset: req_ready=0 during rst, 1 on the first cycle after; resp_valid=0, resp_rdata=0,
//    resp_is_wr=0, resp_err=0.
//    In-flight and queued responses are discarded; array contents are NOT cleared.
//  - No FSM beyond the pipeline valid shift register; state = {stage valids, FIFO ptrs, count}.
// STRUCTURE
//  - Shared package mem_ctrl_pkg:
//    - resp record {is_wr, err, rdata} and its packed width function;
//    - READ_LAT legality check (1..2) and RESP_DEPTH >= READ_LAT+1 check;
//    - the error rdata value (0).
//  - One sub-module: mem_ctrl_resp_fifo. It is a synchronous FIFO, parameters WIDTH and DEPTH,
//    with push/pop/full/empty/count, show-ahead head output and sync active-high reset.
//  - The array is an inferred reg memory in mem_ctrl_rv; it is not a separate module.
// TESTING
//  1. Reset, READ_LAT=1, write 0xDEADBEEF at addr 5 with be=4'hF, then read addr 5
//     -> the write response has is_wr=1, err=0.
//     -> the read response has rdata=0xDEADBEEF, rising one cycle after its accept edge.
//  2. Write 0xFFFFFFFF to addr 9, then write 0x00000000 with be=4'b0101, then read addr 9
//     -> rdata=0xFF00FF00.
//  3. DEPTH=200, read addr 210 -> err=1, rdata=0.
//     Then write addr 210 followed by a read of addr 199 -> the write has no array effect,
//     and addr 199 is unchanged.
//  4. Hold resp_ready=0 with back-to-back reads, RESP_DEPTH=4
//     -> exactly 4 accepts, after which req_ready=0 and the FIFO head is stable.
//     Release resp_ready -> 4 responses in order, req_ready back the cycle after the first pop.
//  5. READ_LAT=2, read streaming with resp_ready=1 -> one accept per cycle.
//     Each resp_valid rises two cycles after its accept; no bubbles, no reorder.
//  6. Assert rst for one cycle with 3 responses queued
//     -> all outputs return to reset values and no stale response appears afterwards.
//     A read of a previously written address still returns the written data.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and parameter checks for the valid/ready RAM controller.
package mem_ctrl_pkg;

  typedef struct packed {
    logic is_wr;
    logic err;
  } resp_flags_t;

  localparam int   RESP_FLAG_W   = $bits(resp_flags_t);
  localparam logic ERR_RDATA_BIT = 1'b0;

  // Full response record is {is_wr, err, rdata}; rdata width is set by the instance.
  function automatic int resp_w(input int data_w);
    return data_w + RESP_FLAG_W;
  endfunction

  function automatic bit read_lat_ok(input int lat);
    return (lat >= 1) && (lat <= 2);
  endfunction

  function automatic bit resp_depth_ok(input int depth, input int lat);
    return depth >= lat + 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_resp_fifo.sv
// Synchronous show-ahead FIFO holding completed responses until the consumer takes them.
module mem_ctrl_resp_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= nxt(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= nxt(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_ctrl_rv.sv
// Single-port RAM controller: byte-enabled writes, 1..2 cycle reads, range errors,
// one in-order response per request, credit-based back-pressure on the request side.
module mem_ctrl_rv
  import mem_ctrl_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int DEPTH      = 256,
  parameter  int READ_LAT   = 1,
  parameter  int RESP_DEPTH = 4,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_is_wr,
  output logic              resp_err
);

  localparam int RESP_W = resp_w(DATA_W);
  localparam int CW     = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic              is_wr;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
    $error("mem_ctrl_rv: READ_LAT must be 1 or 2");
  end
  if (!resp_depth_ok(RESP_DEPTH, READ_LAT)) begin : g_bad_depth
    $error("mem_ctrl_rv: RESP_DEPTH must be >= READ_LAT+1");
  end
  if ($bits(resp_t) != RESP_W) begin : g_bad_w
    $error("mem_ctrl_rv: response record width mismatch");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept, in_range, push, in_flight, pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       outstanding;
  resp_t             resp_acc, push_data, head;

  assign accept   = req_valid && req_ready;
  assign in_range = 32'(req_addr) < DEPTH;

  // Credits count everything that will eventually occupy a FIFO slot.
  assign outstanding = {1'b0, fifo_cnt} + {{CW{1'b0}}, in_flight};
  assign req_ready   = !rst && !fifo_full && (outstanding < (CW+1)'(RESP_DEPTH));

  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    resp_acc       = '0;
    resp_acc.is_wr = req_we;
    resp_acc.err   = !in_range;
    resp_acc.rdata = {DATA_W{ERR_RDATA_BIT}};
    if (in_range && !req_we) resp_acc.rdata = mem[req_addr];
  end

  // The array is sampled at the accept edge; the extra stage only delays the push.
  if (READ_LAT == 1) begin : g_lat1
    assign push      = accept;
    assign push_data = resp_acc;
    assign in_flight = 1'b0;
  end else begin : g_lat2
    logic  stg_vld_q;
    resp_t stg_q;
    always_ff @(posedge clk) begin
      if (rst) stg_vld_q <= 1'b0;
      else     stg_vld_q <= accept;
    end
    always_ff @(posedge clk) begin
      if (accept) stg_q <= resp_acc;
    end
    assign push      = stg_vld_q;
    assign push_data = stg_q;
    assign in_flight = stg_vld_q;
  end

  mem_ctrl_resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Head fields are masked so idle and post-reset outputs read as zero.
  assign resp_valid = !fifo_empty;
  assign pop        = resp_valid && resp_ready;
  assign resp_rdata = resp_valid ? head.rdata : '0;
  assign resp_is_wr = resp_valid && head.is_wr;
  assign resp_err   = resp_valid && head.err;

endmodule

// File: tb/tb_mem_ctrl_rv.sv
// Directed bench: instance A (DEPTH=200, READ_LAT=1), instance B (DEPTH=256, READ_LAT=2).
module tb_mem_ctrl_rv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready;
  logic        a_resp_is_wr, a_resp_err;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready;
  logic        b_resp_is_wr, b_resp_err;
  logic [7:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_be;

  mem_ctrl_rv #(.DATA_W(32), .DEPTH(200), .READ_LAT(1), .RESP_DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
    .resp_is_wr(a_resp_is_wr), .resp_err(a_resp_err)
  );

  mem_ctrl_rv #(.DATA_W(32), .DEPTH(256), .READ_LAT(2), .RESP_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_is_wr(b_resp_is_wr), .resp_err(b_resp_err)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_wr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 14;
  vec_t        vecs [NV];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  t4_addr [4];
  logic [31:0] t4_exp  [4];
  int          acc_iter [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One request on A with resp_ready=1; returns the response and its latency in edges.
  task automatic a_txn(input vec_t v, output logic wr, output logic err,
                       output logic [31:0] rd, output int lat);
    chk1("a_ready_idle", a_req_ready, 1'b1);
    a_req_valid  = 1'b1;
    a_req_we     = v.we;
    a_req_addr   = v.addr;
    a_req_wdata  = v.wdata;
    a_req_be     = v.be;
    a_resp_ready = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    wr = a_resp_is_wr;
    err = a_resp_err;
    rd = a_resp_rdata;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr, err, ok;
    logic [31:0] rd, head0;
    int          lat, acc, idx, stale, r, k, extra;
    vec_t        v;

    vecs[0]  = '{1'b1, 8'd5,   32'hDEADBEEF, 4'hF,    1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 8'd5,   32'h0,        4'h0,    1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 8'd9,   32'hFFFFFFFF, 4'hF,    1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 8'd9,   32'h00000000, 4'b0101, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 8'd9,   32'h0,        4'h0,    1'b0, 1'b0, 32'hFF00FF00};
    vecs[5]  = '{1'b0, 8'd210, 32'h0,        4'h0,    1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 8'd199, 32'h12345678, 4'hF,    1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 8'd210, 32'hAAAAAAAA, 4'hF,    1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 8'd199, 32'h0,        4'h0,    1'b0, 1'b0, 32'h12345678};
    vecs[9]  = '{1'b1, 8'd199, 32'h0,        4'h0,    1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 8'd199, 32'h0,        4'h0,    1'b0, 1'b0, 32'h12345678};
    vecs[11] = '{1'b0, 8'd200, 32'h0,        4'h0,    1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 8'd0,   32'h11223344, 4'hF,    1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 8'd0,   32'h0,        4'h0,    1'b0, 1'b0, 32'h11223344};
    t4_addr[0] = 8'd5;   t4_exp[0] = 32'hDEADBEEF;
    t4_addr[1] = 8'd9;   t4_exp[1] = 32'hFF00FF00;
    t4_addr[2] = 8'd199; t4_exp[2] = 32'h12345678;
    t4_addr[3] = 8'd0;   t4_exp[3] = 32'h11223344;

    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_resp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_resp_ready = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_a_ready", a_req_ready, 1'b0);
    chk1("rst_b_ready", b_req_ready, 1'b0);
    chk1("rst_a_valid", a_resp_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("post_rst_a_ready", a_req_ready, 1'b1);
    chk1("post_rst_b_ready", b_req_ready, 1'b1);
    chk1("post_rst_a_valid", a_resp_valid, 1'b0);
    chk("post_rst_a_rdata", a_resp_rdata, 32'h0);
    chk1("post_rst_a_is_wr", a_resp_is_wr, 1'b0);
    chk1("post_rst_a_err", a_resp_err, 1'b0);

    // Single transactions: write/read, byte enables, range errors, boundaries
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      a_txn(v, wr, err, rd, lat);
      chk1($sformatf("vec%0d_is_wr", i), wr, v.exp_wr);
      chk1($sformatf("vec%0d_err", i), err, v.exp_err);
      chk($sformatf("vec%0d_rdata", i), rd, v.exp_rdata);
      chk($sformatf("vec%0d_latency", i), lat, 1);
    end

    // Back-pressure: fill the FIFO with resp_ready low
    a_resp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      idx = (acc < 4) ? acc : 0;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = t4_addr[idx];
      a_req_wdata = 32'h0; a_req_be = 4'h0;
      ok = a_req_ready;
      @(posedge clk); #1;
      if (ok) acc++;
    end
    a_req_valid = 1'b0;
    chk("t4_accepts", acc, 4);
    chk1("t4_ready_full", a_req_ready, 1'b0);
    chk1("t4_head_valid", a_resp_valid, 1'b1);
    head0 = a_resp_rdata;
    chk("t4_head_rdata", head0, t4_exp[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_head_stable", a_resp_rdata, head0);
    chk1("t4_ready_still_low", a_req_ready, 1'b0);
    a_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("t4_pop%0d_valid", i), a_resp_valid, 1'b1);
      chk($sformatf("t4_pop%0d_rdata", i), a_resp_rdata, t4_exp[i]);
      chk1($sformatf("t4_pop%0d_ready", i), a_req_ready, (i != 0));
      @(posedge clk); #1;
    end
    chk1("t4_drained", a_resp_valid, 1'b0);

    // Reset with 3 responses queued
    a_resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'd9;
      @(posedge clk); #1;
    end
    a_req_valid = 1'b0;
    chk1("t6_queued_valid", a_resp_valid, 1'b1);
    rst = 1'b1;
    #0;
    chk1("t6_ready_in_rst", a_req_ready, 1'b0);
    @(posedge clk); #1;
    chk1("t6_rst_valid", a_resp_valid, 1'b0);
    chk("t6_rst_rdata", a_resp_rdata, 32'h0);
    chk1("t6_rst_is_wr", a_resp_is_wr, 1'b0);
    chk1("t6_rst_err", a_resp_err, 1'b0);
    chk1("t6_rst_ready", a_req_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("t6_post_ready", a_req_ready, 1'b1);
    a_resp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      if (a_resp_valid) stale++;
      @(posedge clk); #1;
    end
    chk("t6_stale_resps", stale, 0);
    v = vecs[4];
    a_txn(v, wr, err, rd, lat);
    chk("t6_mem_kept", rd, 32'hFF00FF00);
    chk1("t6_read_is_wr", wr, 1'b0);

    // READ_LAT=2 streaming: 6 writes then 6 reads, resp_ready held high
    b_resp_ready = 1'b1;
    r = 0; k = 0; extra = 0;
    for (int c = 0; c < 24; c++) begin
      if (b_resp_valid) begin
        if (k < 12) begin
          chk1($sformatf("t5_resp%0d_is_wr", k), b_resp_is_wr, (k < 6));
          chk1($sformatf("t5_resp%0d_err", k), b_resp_err, 1'b0);
          chk($sformatf("t5_resp%0d_rdata", k), b_resp_rdata,
              (k < 6) ? 32'h0 : (32'hA0000000 + 32'(k - 6)));
          chk($sformatf("t5_resp%0d_latency", k), c, acc_iter[k] + 2);
        end else begin
          extra++;
        end
        k++;
      end
      if (r < 12) begin
        b_req_valid = 1'b1;
        b_req_we    = (r < 6);
        b_req_addr  = 8'((r % 6) * 7);
        b_req_wdata = 32'hA0000000 + 32'(r);
        b_req_be    = 4'hF;
        ok = b_req_ready;
        chk1($sformatf("t5_ready%0d", r), ok, 1'b1);
      end else begin
        b_req_valid = 1'b0;
        ok = 1'b0;
      end
      @(posedge clk); #1;
      if (ok) begin
        acc_iter[r] = c;
        r++;
      end
    end
    b_req_valid = 1'b0;
    chk("t5_accepts", r, 12);
    chk("t5_responses", k, 12);
    chk("t5_extra", extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
